// File: rtl/ccd_seq_pkg.sv
// ---------------------------------------------------------------------------
// ccd_seq_pkg
// Shared types and constants for the CCD capture sequencer:
//   fsm_state_t      sequencer FSM states
//   ERR_*            2-bit error codes reported on ERR_CODE
//   SEQ_*            FT4052C timing-generator state encodings (SEQ_STATE)
//   end_timeout_us   integration + margin, saturated to 33 bits
// ---------------------------------------------------------------------------
package ccd_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ARM        = 3'd1,
        S_WAIT_START = 3'd2,
        S_WAIT_END   = 3'd3,
        S_GAP        = 3'd4,
        S_FINISH     = 3'd5
    } fsm_state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_BAD_CMD  = 2'b01;
    localparam logic [1:0] ERR_START_TO = 2'b10;
    localparam logic [1:0] ERR_END_TO   = 2'b11;

    localparam logic [2:0] SEQ_IDLE        = 3'd0;
    localparam logic [2:0] SEQ_SHUTTER_ON  = 3'd1;
    localparam logic [2:0] SEQ_RESET       = 3'd2;
    localparam logic [2:0] SEQ_INTEG       = 3'd3;
    localparam logic [2:0] SEQ_SHUTTER_OFF = 3'd4;
    localparam logic [2:0] SEQ_READOUT     = 3'd5;

    // Per-frame end timeout in microseconds. The sum is formed one bit wider
    // than the timer so a large margin clamps to the longest timeout instead
    // of wrapping to a short one.
    function automatic logic [32:0] end_timeout_us(input logic [31:0] integ,
                                                   input logic [32:0] margin);
        logic [33:0] sum;
        sum = {2'b00, integ} + {1'b0, margin};
        return sum[33] ? {33{1'b1}} : sum[32:0];
    endfunction

endpackage

// File: rtl/ccd_us_timer.sv
// ---------------------------------------------------------------------------
// ccd_us_timer
// Microsecond down-counter with a CLKS_PER_US clock prescaler.
//   CLK      in   clock
//   reset    in   synchronous, active-low
//   load     in   load load_us and restart the prescaler
//   load_us  in   33-bit duration in microseconds
//   run      in   count while high
//   expired  out  microsecond count has reached zero
// A load of N us with run held high raises expired after N*CLKS_PER_US
// cycles; a load of 0 is expired immediately.
// ---------------------------------------------------------------------------
module ccd_us_timer #(
    parameter int unsigned CLKS_PER_US = 48
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        load,
    input  logic [32:0] load_us,
    input  logic        run,
    output logic        expired
);

    localparam int PW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(CLKS_PER_US - 1);

    logic [PW-1:0] pre;
    logic [32:0]   us_cnt;

    always_ff @(posedge CLK) begin
        if (!reset) begin
            pre    <= '0;
            us_cnt <= '0;
        end else if (load) begin
            pre    <= '0;
            us_cnt <= load_us;
        end else if (run && (us_cnt != '0)) begin
            if (pre == PRE_LAST) begin
                pre    <= '0;
                us_cnt <= us_cnt - 33'd1;
            end else begin
                pre <= pre + 1'b1;
            end
        end
    end

    assign expired = (us_cnt == '0);

endmodule

// File: rtl/ccd_capture_sequencer.sv
// ---------------------------------------------------------------------------
// ccd_capture_sequencer
// Frame-burst scheduler in front of the FT4052C CCD timing generator.
// Takes one host command (integration us, frame count, inter-frame gap us),
// triggers the generator once per frame, follows SEQ_STATE to find frame
// start/end, and reports per-frame and per-burst completion.
//   CLK, reset                       clock, synchronous active-low reset
//   CMD_VALID/CMD_READY              command handshake
//   CMD_INTEGRATION/FRAMES/GAP       command fields
//   ABORT                            stop burst after the current frame
//   SEQ_STATE                        generator state (0 = idle)
//   TRIGGER, INTEGRATION             generator controls
//   BUSY, FRAME_DONE, FRAME_INDEX    burst progress
//   SEQ_DONE, SEQ_ABORTED            burst completion
//   ERROR, ERR_CODE                  sticky error until next accept
// ---------------------------------------------------------------------------
module ccd_capture_sequencer
    import ccd_seq_pkg::*;
#(
    parameter int unsigned CLKS_PER_US   = 48,
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned END_MARGIN_US = 4000000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [31:0] CMD_INTEGRATION,
    input  logic [15:0] CMD_FRAMES,
    input  logic [31:0] CMD_GAP,
    input  logic        ABORT,
    input  logic [2:0]  SEQ_STATE,
    output logic        TRIGGER,
    output logic [31:0] INTEGRATION,
    output logic        BUSY,
    output logic        FRAME_DONE,
    output logic [15:0] FRAME_INDEX,
    output logic        SEQ_DONE,
    output logic        SEQ_ABORTED,
    output logic        ERROR,
    output logic [1:0]  ERR_CODE
);

    localparam int SCW = $clog2(START_TIMEOUT + 1);
    localparam logic [SCW-1:0] START_LAST = SCW'(START_TIMEOUT - 1);

    fsm_state_t state, next_state;

    logic [15:0]    frames_r;
    logic [31:0]    gap_r;
    logic           abort_pending;
    logic           aborted_r;
    logic [SCW-1:0] start_cnt;

    logic        accept;
    logic        seq_idle;
    logic        frame_end;
    logic        last_frame;
    logic        start_expired;
    logic        abort_exit;
    logic        tmr_load;
    logic        tmr_run;
    logic [32:0] tmr_value;
    logic        tmr_expired;

    assign seq_idle      = (SEQ_STATE == SEQ_IDLE);
    assign accept        = CMD_VALID && CMD_READY;
    assign frame_end     = (state == S_WAIT_END) && seq_idle;
    assign last_frame    = ((FRAME_INDEX + 16'd1) == frames_r);
    assign start_expired = (start_cnt == START_LAST);

    // Burst ends early because of ABORT only when a frame boundary is reached
    // with frames still outstanding; an abort landing on the final frame is a
    // normal completion.
    assign abort_exit = abort_pending &&
                        ((frame_end && !last_frame) || (state == S_GAP));

    // ---------------- state register ----------------
    always_ff @(posedge CLK) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept && (CMD_FRAMES != 16'd0)) next_state = S_ARM;
            end
            S_ARM: begin
                if (seq_idle) next_state = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (!seq_idle)          next_state = S_WAIT_END;
                else if (start_expired) next_state = S_FINISH;
            end
            S_WAIT_END: begin
                // Frame end wins over a timeout landing in the same cycle.
                if (seq_idle) begin
                    if (last_frame || abort_pending) next_state = S_FINISH;
                    else if (gap_r == 32'd0)         next_state = S_ARM;
                    else                             next_state = S_GAP;
                end else if (tmr_expired) begin
                    next_state = S_FINISH;
                end
            end
            S_GAP: begin
                if (abort_pending)    next_state = S_FINISH;
                else if (tmr_expired) next_state = S_ARM;
            end
            S_FINISH: next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // ---------------- outputs ----------------
    // READY also waits for the generator: after a timeout or a reset in the
    // middle of a frame the generator may still be running.
    always_comb begin
        CMD_READY   = (state == S_IDLE) && seq_idle;
        TRIGGER     = (state == S_ARM) && seq_idle;
        BUSY        = (state != S_IDLE);
        SEQ_DONE    = (state == S_FINISH);
        SEQ_ABORTED = (state == S_FINISH) && aborted_r;
    end

    // ---------------- shared us timer ----------------
    // WAIT_END and GAP never overlap, so one timer serves both; it is loaded
    // on the transition into either state.
    assign tmr_load  = ((state == S_WAIT_START) && (next_state == S_WAIT_END)) ||
                       ((state == S_WAIT_END)   && (next_state == S_GAP));
    assign tmr_value = (state == S_WAIT_END) ? {1'b0, gap_r}
                                             : end_timeout_us(INTEGRATION, 33'(END_MARGIN_US));
    assign tmr_run   = (state == S_WAIT_END) || (state == S_GAP);

    ccd_us_timer #(
        .CLKS_PER_US (CLKS_PER_US)
    ) u_timer (
        .CLK     (CLK),
        .reset   (reset),
        .load    (tmr_load),
        .load_us (tmr_value),
        .run     (tmr_run),
        .expired (tmr_expired)
    );

    // ---------------- datapath ----------------
    always_ff @(posedge CLK) begin
        if (!reset) begin
            INTEGRATION   <= '0;
            frames_r      <= '0;
            gap_r         <= '0;
            FRAME_INDEX   <= '0;
            FRAME_DONE    <= 1'b0;
            abort_pending <= 1'b0;
            aborted_r     <= 1'b0;
            ERROR         <= 1'b0;
            ERR_CODE      <= ERR_NONE;
            start_cnt     <= '0;
        end else begin
            // Registered so FRAME_DONE and the new FRAME_INDEX appear together.
            FRAME_DONE <= frame_end;
            aborted_r  <= (next_state == S_FINISH) && abort_exit;

            if (state == S_WAIT_START) start_cnt <= start_cnt + 1'b1;
            else                       start_cnt <= '0;

            if (accept) begin
                INTEGRATION   <= CMD_INTEGRATION;
                frames_r      <= CMD_FRAMES;
                gap_r         <= CMD_GAP;
                FRAME_INDEX   <= '0;
                abort_pending <= 1'b0;
                ERROR         <= (CMD_FRAMES == 16'd0);
                ERR_CODE      <= (CMD_FRAMES == 16'd0) ? ERR_BAD_CMD : ERR_NONE;
            end else begin
                if (state == S_FINISH)    abort_pending <= 1'b0;
                else if (BUSY && ABORT)   abort_pending <= 1'b1;

                if (frame_end) FRAME_INDEX <= FRAME_INDEX + 16'd1;

                if ((state == S_WAIT_START) && (next_state == S_FINISH)) begin
                    ERROR    <= 1'b1;
                    ERR_CODE <= ERR_START_TO;
                end
                if ((state == S_WAIT_END) && !seq_idle && (next_state == S_FINISH)) begin
                    ERROR    <= 1'b1;
                    ERR_CODE <= ERR_END_TO;
                end
            end
        end
    end

endmodule

// File: tb/tb_ccd_capture_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ccd_capture_sequencer
// Self-checking bench for ccd_capture_sequencer with a behavioural model of
// the timing generator (idle -> 1..5 -> idle per TRIGGER, each phase
// gen_phase cycles). Expected FRAME_DONE indices and SEQ_DONE records are
// queued when a command is issued and compared when the DUT reports them.
// Timing parameters are shrunk so timeouts are reachable quickly.
// ---------------------------------------------------------------------------
module tb_ccd_capture_sequencer;

    localparam int CPU = 4;
    localparam int STO = 16;
    localparam int EMU = 20;

    logic        CLK = 1'b0;
    logic        reset = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [31:0] CMD_INTEGRATION = '0;
    logic [15:0] CMD_FRAMES = '0;
    logic [31:0] CMD_GAP = '0;
    logic        ABORT = 1'b0;
    logic [2:0]  SEQ_STATE;
    logic        TRIGGER;
    logic [31:0] INTEGRATION;
    logic        BUSY;
    logic        FRAME_DONE;
    logic [15:0] FRAME_INDEX;
    logic        SEQ_DONE;
    logic        SEQ_ABORTED;
    logic        ERROR;
    logic [1:0]  ERR_CODE;

    ccd_capture_sequencer #(
        .CLKS_PER_US   (CPU),
        .START_TIMEOUT (STO),
        .END_MARGIN_US (EMU)
    ) dut (
        .CLK             (CLK),
        .reset           (reset),
        .CMD_VALID       (CMD_VALID),
        .CMD_READY       (CMD_READY),
        .CMD_INTEGRATION (CMD_INTEGRATION),
        .CMD_FRAMES      (CMD_FRAMES),
        .CMD_GAP         (CMD_GAP),
        .ABORT           (ABORT),
        .SEQ_STATE       (SEQ_STATE),
        .TRIGGER         (TRIGGER),
        .INTEGRATION     (INTEGRATION),
        .BUSY            (BUSY),
        .FRAME_DONE      (FRAME_DONE),
        .FRAME_INDEX     (FRAME_INDEX),
        .SEQ_DONE        (SEQ_DONE),
        .SEQ_ABORTED     (SEQ_ABORTED),
        .ERROR           (ERROR),
        .ERR_CODE        (ERR_CODE)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int trig_cnt = 0;

    typedef struct {
        logic        ab;
        logic [1:0]  err;
        logic [15:0] idx;
    } done_t;

    done_t       exp_done_q[$];
    logic [15:0] exp_frame_q[$];
    done_t       mon_d;
    logic [15:0] mon_f;

    // ---------------- timing generator model ----------------
    // gen_mode: 0 normal, 1 never leaves idle, 2 sticks in state 1
    logic [2:0] gen_state = 3'd0;
    int         gen_tick = 0;
    int         gen_phase = 2;
    int         gen_mode = 0;
    logic       gen_force = 1'b0;
    logic [2:0] gen_force_val = 3'd0;

    assign SEQ_STATE = gen_state;

    always @(posedge CLK) begin
        if (gen_force) begin
            gen_state <= gen_force_val;
            gen_tick  <= 0;
        end else if (gen_state == 3'd0) begin
            if (TRIGGER && gen_mode != 1) begin
                gen_state <= 3'd1;
                gen_tick  <= 0;
            end
        end else if (gen_mode == 2) begin
            gen_state <= gen_state;
        end else if (gen_tick >= gen_phase - 1) begin
            gen_tick  <= 0;
            gen_state <= (gen_state == 3'd5) ? 3'd0 : gen_state + 3'd1;
        end else begin
            gen_tick <= gen_tick + 1;
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (reset) begin
            if (TRIGGER) trig_cnt++;
            if (FRAME_DONE) begin
                checks++;
                if (exp_frame_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame_done index=%0d required=none", FRAME_INDEX);
                end else begin
                    mon_f = exp_frame_q.pop_front();
                    if (FRAME_INDEX !== mon_f) begin
                        errors++;
                        $display("FAIL frame_index got=%0d required=%0d", FRAME_INDEX, mon_f);
                    end
                end
            end
            if (SEQ_DONE) begin
                checks++;
                if (exp_done_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_seq_done idx=%0d required=none", FRAME_INDEX);
                end else begin
                    mon_d = exp_done_q.pop_front();
                    if (SEQ_ABORTED !== mon_d.ab || ERR_CODE !== mon_d.err || FRAME_INDEX !== mon_d.idx) begin
                        errors++;
                        $display("FAIL seq_done got ab=%b err=%b idx=%0d required ab=%b err=%b idx=%0d",
                                 SEQ_ABORTED, ERR_CODE, FRAME_INDEX, mon_d.ab, mon_d.err, mon_d.idx);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic push_frames(input int n);
        for (int i = 1; i <= n; i++) exp_frame_q.push_back(16'(i));
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic send_cmd(input logic [31:0] integ, input logic [15:0] fr, input logic [31:0] gap);
        int k;
        CMD_INTEGRATION = integ;
        CMD_FRAMES      = fr;
        CMD_GAP         = gap;
        CMD_VALID       = 1'b1;
        k = 0;
        while (!CMD_READY && k < 200) begin
            @(negedge CLK);
            k++;
        end
        checks++;
        if (CMD_READY !== 1'b1) begin
            errors++;
            $display("FAIL cmd_accept_timeout ready=%b required=1", CMD_READY);
        end
        @(negedge CLK);
        CMD_VALID = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int k;
        k = 0;
        while (SEQ_DONE !== 1'b1 && k < budget) begin
            @(negedge CLK);
            k++;
        end
        checks++;
        if (SEQ_DONE !== 1'b1) begin
            errors++;
            $display("FAIL %s seq_done_timeout got=%b required=1", name, SEQ_DONE);
        end
        tick(2);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_frame_q.size() != 0 || exp_done_q.size() != 0) begin
            errors++;
            $display("FAIL %s scoreboard_left frames=%0d dones=%0d required=0 0",
                     name, exp_frame_q.size(), exp_done_q.size());
            exp_frame_q.delete();
            exp_done_q.delete();
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        tick(3);
        checks++;
        if (BUSY !== 1'b0 || TRIGGER !== 1'b0 || SEQ_DONE !== 1'b0 || FRAME_DONE !== 1'b0 ||
            ERROR !== 1'b0 || ERR_CODE !== 2'b00 || FRAME_INDEX !== 16'd0 || INTEGRATION !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs busy=%b trig=%b done=%b fdone=%b err=%b code=%b idx=%0d integ=%0d required all 0",
                     BUSY, TRIGGER, SEQ_DONE, FRAME_DONE, ERROR, ERR_CODE, FRAME_INDEX, INTEGRATION);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (CMD_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b required=1", CMD_READY);
        end
    endtask

    task automatic test_burst();
        int t0;
        gen_phase = 2;
        t0 = trig_cnt;
        push_frames(3);
        exp_done_q.push_back('{1'b0, 2'b00, 16'd3});
        send_cmd(32'd10, 16'd3, 32'd5);
        checks++;
        if (BUSY !== 1'b1 || INTEGRATION !== 32'd10) begin
            errors++;
            $display("FAIL burst_start busy=%b integ=%0d required busy=1 integ=10", BUSY, INTEGRATION);
        end
        wait_done(2000, "burst");
        checks++;
        if (trig_cnt - t0 != 3) begin
            errors++;
            $display("FAIL burst_triggers got=%0d required=3", trig_cnt - t0);
        end
        checks++;
        if (ERROR !== 1'b0 || BUSY !== 1'b0 || FRAME_INDEX !== 16'd3) begin
            errors++;
            $display("FAIL burst_end err=%b busy=%b idx=%0d required err=0 busy=0 idx=3", ERROR, BUSY, FRAME_INDEX);
        end
        check_drained("burst");
    endtask

    task automatic test_bad_cmd();
        int t0;
        t0 = trig_cnt;
        send_cmd(32'd7, 16'd0, 32'd0);
        checks++;
        if (ERROR !== 1'b1 || ERR_CODE !== 2'b01 || BUSY !== 1'b0 || CMD_READY !== 1'b1) begin
            errors++;
            $display("FAIL bad_cmd err=%b code=%b busy=%b ready=%b required err=1 code=01 busy=0 ready=1",
                     ERROR, ERR_CODE, BUSY, CMD_READY);
        end
        tick(10);
        checks++;
        if (trig_cnt != t0 || BUSY !== 1'b0 || ERROR !== 1'b1) begin
            errors++;
            $display("FAIL bad_cmd_idle triggers=%0d busy=%b err=%b required triggers=0 busy=0 err=1",
                     trig_cnt - t0, BUSY, ERROR);
        end
    endtask

    // Two frames with no gap; ABORT is high only while the sequencer is idle
    // (up to and including the accept edge) and must be ignored.
    task automatic test_back_to_back();
        int t0;
        gen_phase = 2;
        t0 = trig_cnt;
        push_frames(2);
        exp_done_q.push_back('{1'b0, 2'b00, 16'd2});
        ABORT = 1'b1;
        send_cmd(32'd10, 16'd2, 32'd0);
        ABORT = 1'b0;
        checks++;
        if (ERROR !== 1'b0 || ERR_CODE !== 2'b00) begin
            errors++;
            $display("FAIL accept_clears_error err=%b code=%b required err=0 code=00", ERROR, ERR_CODE);
        end
        wait_done(1000, "back_to_back");
        checks++;
        if (trig_cnt - t0 != 2) begin
            errors++;
            $display("FAIL b2b_triggers got=%0d required=2", trig_cnt - t0);
        end
        check_drained("back_to_back");
    endtask

    task automatic test_abort();
        int t0;
        int k;
        gen_phase = 3;
        t0 = trig_cnt;
        push_frames(2);
        exp_done_q.push_back('{1'b1, 2'b00, 16'd2});
        send_cmd(32'd10, 16'd5, 32'd5);
        k = 0;
        while (trig_cnt < t0 + 2 && k < 500) begin
            @(negedge CLK);
            k++;
        end
        ABORT = 1'b1;
        tick(1);
        ABORT = 1'b0;
        wait_done(2000, "abort");
        checks++;
        if (trig_cnt - t0 != 2 || ERROR !== 1'b0) begin
            errors++;
            $display("FAIL abort_triggers got=%0d err=%b required=2 err=0", trig_cnt - t0, ERROR);
        end
        check_drained("abort");
    endtask

    // Generator ignores TRIGGER: 16 cycles in WAIT_START, then FINISH.
    task automatic test_start_timeout();
        int t0;
        int k;
        int n;
        gen_mode = 1;
        t0 = trig_cnt;
        exp_done_q.push_back('{1'b0, 2'b10, 16'd0});
        send_cmd(32'd10, 16'd2, 32'd0);
        k = 0;
        while (TRIGGER !== 1'b1 && k < 20) begin
            @(negedge CLK);
            k++;
        end
        n = 0;
        while (SEQ_DONE !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n != STO + 1) begin
            errors++;
            $display("FAIL start_timeout_latency got=%0d required=%0d", n, STO + 1);
        end
        tick(2);
        checks++;
        if (ERROR !== 1'b1 || ERR_CODE !== 2'b10 || trig_cnt - t0 != 1) begin
            errors++;
            $display("FAIL start_timeout err=%b code=%b triggers=%0d required err=1 code=10 triggers=1",
                     ERROR, ERR_CODE, trig_cnt - t0);
        end
        gen_mode = 0;
        check_drained("start_timeout");
    endtask

    // Generator starts but never returns to idle: end timeout, READY held off.
    task automatic test_end_timeout();
        gen_mode = 2;
        exp_done_q.push_back('{1'b0, 2'b11, 16'd0});
        send_cmd(32'd3, 16'd2, 32'd0);
        wait_done((3 + EMU) * CPU + 100, "end_timeout");
        checks++;
        if (ERROR !== 1'b1 || ERR_CODE !== 2'b11 || BUSY !== 1'b0 || CMD_READY !== 1'b0) begin
            errors++;
            $display("FAIL end_timeout err=%b code=%b busy=%b ready=%b required err=1 code=11 busy=0 ready=0",
                     ERROR, ERR_CODE, BUSY, CMD_READY);
        end
        gen_mode      = 0;
        gen_force_val = 3'd0;
        gen_force     = 1'b1;
        tick(1);
        gen_force = 1'b0;
        checks++;
        if (CMD_READY !== 1'b1) begin
            errors++;
            $display("FAIL end_timeout_recover ready=%b required=1", CMD_READY);
        end
        check_drained("end_timeout");
    endtask

    task automatic test_reset_mid();
        int t0;
        int k;
        gen_phase = 4;
        t0 = trig_cnt;
        send_cmd(32'd10, 16'd3, 32'd0);
        k = 0;
        while (trig_cnt == t0 && k < 20) begin
            @(negedge CLK);
            k++;
        end
        tick(5);
        reset = 1'b0;
        tick(2);
        checks++;
        if (BUSY !== 1'b0 || TRIGGER !== 1'b0 || SEQ_DONE !== 1'b0 || FRAME_INDEX !== 16'd0 ||
            INTEGRATION !== 32'd0 || CMD_READY !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid busy=%b trig=%b done=%b idx=%0d integ=%0d ready=%b required 0 0 0 0 0 0",
                     BUSY, TRIGGER, SEQ_DONE, FRAME_INDEX, INTEGRATION, CMD_READY);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (CMD_READY !== 1'b0 || SEQ_STATE == 3'd0) begin
            errors++;
            $display("FAIL reset_mid_ready ready=%b seq=%0d required ready=0 seq!=0", CMD_READY, SEQ_STATE);
        end
        k = 0;
        while (SEQ_STATE != 3'd0 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        checks++;
        if (CMD_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_release ready=%b required=1", CMD_READY);
        end
        tick(3);
        check_drained("reset_mid");
    endtask

    // CMD_VALID held through reset while the generator reads out.
    task automatic test_ready_hold();
        logic early;
        int   k;
        gen_force_val   = 3'd5;
        gen_force       = 1'b1;
        reset           = 1'b0;
        CMD_INTEGRATION = 32'd2;
        CMD_FRAMES      = 16'd1;
        CMD_GAP         = 32'd0;
        CMD_VALID       = 1'b1;
        tick(2);
        reset = 1'b1;
        early = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (BUSY !== 1'b0 || CMD_READY !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early !== 1'b0) begin
            errors++;
            $display("FAIL ready_hold early_accept=%b required=0", early);
        end
        push_frames(1);
        exp_done_q.push_back('{1'b0, 2'b00, 16'd1});
        gen_force_val = 3'd0;
        tick(1);
        gen_force = 1'b0;
        k = 0;
        while (BUSY !== 1'b1 && k < 20) begin
            @(negedge CLK);
            k++;
        end
        CMD_VALID = 1'b0;
        checks++;
        if (BUSY !== 1'b1) begin
            errors++;
            $display("FAIL ready_hold_accept busy=%b required=1", BUSY);
        end
        wait_done(500, "ready_hold");
        checks++;
        if (FRAME_INDEX !== 16'd1 || ERROR !== 1'b0) begin
            errors++;
            $display("FAIL ready_hold_end idx=%0d err=%b required idx=1 err=0", FRAME_INDEX, ERROR);
        end
        check_drained("ready_hold");
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_burst();
        test_bad_cmd();
        test_back_to_back();
        test_abort();
        test_start_timeout();
        test_end_timeout();
        test_reset_mid();
        test_ready_hold();
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
